obstacle_spawn_scheduler: RTL and testbench
===========================================

// Module: obstacle_spawn_scheduler
// PURPOSE
//  Sequences obstacle spawning for the dino game from the 2-bit random source.
//  Paces spawns with a frame-tick gap counter and samples rnd once per gap.
//  Offers each obstacle to the obstacle renderer over a valid/ready handshake.
//  Configures the random generator's divider counts (mcnt1/mcnt2) from a score-derived level.
// PARAMETERS
//  MIN_GAP    24   frames between spawns at level 0, type 0 offset
//  GAP_STEP   8    extra frames per unit of spawned type
//  LVL_SHRINK 4    frames removed from the gap per level
//  GAP_FLOOR  12   minimum reload value of the gap counter
//  LVL_SCORE  100  score points per level step (levels 0..3)
//  SCORE_W    10   score width
// PORTS
//  clk          in   1        system clock (10 MHz)
//  rst_n        in   1        asynchronous active-low reset
//  state        in   state_t  game state: IDLE/RUN/OVER/WIN
//  frame_tick   in   1        one-cycle pulse per frame
//  rnd          in   2        random generator output
//  score        in   SCORE_W  current score
//  spawn_ready  in   1        renderer can accept an obstacle
//  spawn_valid  out  1        obstacle offer valid
//  spawn_type   out  2        obstacle type (1..3); 0 never offered
//  level        out  2        difficulty level 0..3
//  mcnt1        out  4        divider count for LFSR1 clock
//  mcnt2        out  4        divider count for LFSR2 clock
// BEHAVIOUR
//  Reset values: spawn_valid=0, spawn_type=0, level=0, mcnt1=7, mcnt2=2, FSM=S_OFF, gap_cnt=MIN_GAP.
//  FSM states: S_OFF, S_GAP, S_SAMPLE, S_OFFER.
//  - S_OFF: entered whenever state!=RUN, from any FSM state, on the next clk.
//    - Forces spawn_valid=0 and gap_cnt=MIN_GAP.
//    - Goes to S_GAP on the first cycle state==RUN.
//  - S_GAP: on frame_tick, decrement gap_cnt.
//    - A tick with gap_cnt==1 sets gap_cnt to 0 and moves to S_SAMPLE.
//    - Ticks outside S_GAP are ignored.
//  - S_SAMPLE: one cycle; latch rnd into type_q.
//    - type_q==0: no spawn; reload gap_cnt=GAP_STEP; go to S_GAP.
//    - type_q!=0: go to S_OFFER.
//  - S_OFFER: spawn_valid=1 and spawn_type=type_q, both held stable until spawn_ready.
//    - On valid&&ready: drop valid next cycle, reload gap, go to S_GAP.
//  Gap reload: g = MIN_GAP + type_q*GAP_STEP - level*LVL_SHRINK.
//    - gap_cnt = max(g, GAP_FLOOR); compute in 9-bit signed so underflow clamps.
//    - gap_cnt is 8 bits.
//  Level: registered, recomputed every cycle while state==RUN:
//    - score >= 3*LVL_SCORE -> 3; else >= 2*LVL_SCORE -> 2; else >= LVL_SCORE -> 1; else 0.
//    - Compares only, no divider.
//    - Held in OVER/WIN; cleared to 0 in IDLE.
//  mcnt1/mcnt2: registered lookup of level.
//    - L0 = 7/2, L1 = 6/3, L2 = 5/3, L3 = 4/3.
//    - Update one cycle after level; never 0 or 1.
//  Simultaneous events:
//    - valid&&ready in the same cycle state leaves RUN: the transfer counts (consumer takes it); FSM still goes to S_OFF.
//    - frame_tick in the S_SAMPLE/S_OFFER cycle: ignored; no tick banking.
//  Reset mid-offer: spawn_valid drops asynchronously; no partial transfer is implied.
// STRUCTURE
//  dino_pkg (shared):
//    - state_t (IDLE, RUN, OVER, WIN).
//    - spawn_fsm_t.
//    - MCNT lookup table constants.
//  One sub-module: spawn_level_ctrl.
//    - score -> level -> mcnt1/mcnt2 registers.
//    - Separately reusable by the score display.
// TESTING
//  1. Reset, state=RUN, rnd=2 held, ready=1:
//     - First valid after 24 ticks + 2 clk, type=2.
//     - Next valid 40 ticks later.
//  2. ready=0 for 50 clk during an offer:
//     - valid and type stay stable; rnd changes don't alter spawn_type.
//     - Single transfer when ready rises.
//  3. rnd=0 at sample:
//     - No valid; next sample 8 ticks later.
//  4. score=350, rnd=1, ready=1:
//     - level=3, mcnt1=4, mcnt2=3.
//     - Gap = max(24+8-12, 12) = 20 ticks.
//  5. state RUN->OVER mid-gap, then OVER->IDLE->RUN:
//     - valid=0; level held in OVER, 0 in IDLE.
//     - First spawn again after 24 ticks.
//  6. rst_n low while valid=1:
//     - valid, type and level return to 0 immediately; mcnt1=7, mcnt2=2.

Source files
------------

// File: rtl/dino_pkg.sv
// dino_pkg
//   Shared types and constants for the dino game blocks.
//   - state_t     : top-level game state (IDLE/RUN/OVER/WIN)
//   - spawn_fsm_t : obstacle spawn sequencer states
//   - MCNT lookup : LFSR clock divider counts per difficulty level
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2,
    WIN  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    S_OFF    = 2'd0,
    S_GAP    = 2'd1,
    S_SAMPLE = 2'd2,
    S_OFFER  = 2'd3
  } spawn_fsm_t;

  // Divider counts per level. Both stay >= 2 so the random source
  // clocks are always divided.
  localparam logic [3:0] MCNT1_L0 = 4'd7;
  localparam logic [3:0] MCNT1_L1 = 4'd6;
  localparam logic [3:0] MCNT1_L2 = 4'd5;
  localparam logic [3:0] MCNT1_L3 = 4'd4;
  localparam logic [3:0] MCNT2_L0 = 4'd2;
  localparam logic [3:0] MCNT2_L1 = 4'd3;
  localparam logic [3:0] MCNT2_L2 = 4'd3;
  localparam logic [3:0] MCNT2_L3 = 4'd3;

  function automatic logic [3:0] mcnt1_lut(input logic [1:0] lvl);
    logic [3:0] m;
    case (lvl)
      2'd0:    m = MCNT1_L0;
      2'd1:    m = MCNT1_L1;
      2'd2:    m = MCNT1_L2;
      default: m = MCNT1_L3;
    endcase
    return m;
  endfunction

  function automatic logic [3:0] mcnt2_lut(input logic [1:0] lvl);
    logic [3:0] m;
    case (lvl)
      2'd0:    m = MCNT2_L0;
      2'd1:    m = MCNT2_L1;
      2'd2:    m = MCNT2_L2;
      default: m = MCNT2_L3;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/obstacle_spawn_scheduler_level_ctrl.sv
// spawn_level_ctrl
//   Derives the difficulty level from the score and registers the random
//   generator divider counts for that level. Usable on its own (e.g. by the
//   score display).
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   state      : game state; level tracks score in RUN, holds in OVER/WIN,
//                clears in IDLE
//   score      : current score
//   level      : registered level 0..3
//   mcnt1/2    : registered divider counts, one cycle behind level
module spawn_level_ctrl
  import dino_pkg::*;
#(
  parameter int LVL_SCORE = 100,
  parameter int SCORE_W   = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  state_t             state,
  input  logic [SCORE_W-1:0] score,
  output logic [1:0]         level,
  output logic [3:0]         mcnt1,
  output logic [3:0]         mcnt2
);

  logic [1:0] level_reg;
  logic [1:0] level_calc;
  logic [3:0] mcnt1_reg;
  logic [3:0] mcnt2_reg;

  // Threshold compares instead of a divide by LVL_SCORE.
  always_comb begin
    level_calc = 2'd0;
    if (int'(score) >= 3 * LVL_SCORE)      level_calc = 2'd3;
    else if (int'(score) >= 2 * LVL_SCORE) level_calc = 2'd2;
    else if (int'(score) >= LVL_SCORE)     level_calc = 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_reg <= 2'd0;
      mcnt1_reg <= MCNT1_L0;
      mcnt2_reg <= MCNT2_L0;
    end else begin
      if (state == RUN)       level_reg <= level_calc;
      else if (state == IDLE) level_reg <= 2'd0;
      mcnt1_reg <= mcnt1_lut(level_reg);
      mcnt2_reg <= mcnt2_lut(level_reg);
    end
  end

  assign level = level_reg;
  assign mcnt1 = mcnt1_reg;
  assign mcnt2 = mcnt2_reg;

endmodule

// File: rtl/obstacle_spawn_scheduler.sv
// obstacle_spawn_scheduler
//   Paces obstacle spawns with a frame-tick gap counter, samples the random
//   source once per gap and offers each obstacle over valid/ready. Also
//   drives the random generator divider counts from a score-derived level.
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   state        : game state; anything but RUN parks the sequencer
//   frame_tick   : one-cycle pulse per frame
//   rnd          : random source, sampled once per gap
//   score        : current score
//   spawn_ready  : renderer accepts the offered obstacle
//   spawn_valid  : obstacle offer valid
//   spawn_type   : obstacle type 1..3 while valid
//   level        : difficulty level 0..3
//   mcnt1, mcnt2 : divider counts for the two LFSR clocks
module obstacle_spawn_scheduler
  import dino_pkg::*;
#(
  parameter int MIN_GAP    = 24,
  parameter int GAP_STEP   = 8,
  parameter int LVL_SHRINK = 4,
  parameter int GAP_FLOOR  = 12,
  parameter int LVL_SCORE  = 100,
  parameter int SCORE_W    = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  state_t             state,
  input  logic               frame_tick,
  input  logic [1:0]         rnd,
  input  logic [SCORE_W-1:0] score,
  input  logic               spawn_ready,
  output logic               spawn_valid,
  output logic [1:0]         spawn_type,
  output logic [1:0]         level,
  output logic [3:0]         mcnt1,
  output logic [3:0]         mcnt2
);

  localparam logic signed [8:0] MIN_GAP_S    = 9'(MIN_GAP);
  localparam logic signed [8:0] GAP_STEP_S   = 9'(GAP_STEP);
  localparam logic signed [8:0] LVL_SHRINK_S = 9'(LVL_SHRINK);
  localparam logic signed [8:0] GAP_FLOOR_S  = 9'(GAP_FLOOR);

  spawn_fsm_t        fsm_reg, fsm_next;
  logic [7:0]        gap_cnt_reg, gap_cnt_next;
  logic [1:0]        type_q_reg, type_q_next;
  logic signed [8:0] gap_raw;
  logic [7:0]        gap_reload;

  spawn_level_ctrl #(
    .LVL_SCORE (LVL_SCORE),
    .SCORE_W   (SCORE_W)
  ) u_level_ctrl (
    .clk   (clk),
    .rst_n (rst_n),
    .state (state),
    .score (score),
    .level (level),
    .mcnt1 (mcnt1),
    .mcnt2 (mcnt2)
  );

  // Gap after a delivered obstacle: larger obstacles get more room, higher
  // levels less. Signed 9-bit so a large shrink clamps to the floor instead
  // of wrapping.
  always_comb begin
    gap_raw = MIN_GAP_S
            + $signed({7'd0, type_q_reg}) * GAP_STEP_S
            - $signed({7'd0, level}) * LVL_SHRINK_S;
    gap_reload = (gap_raw < GAP_FLOOR_S) ? GAP_FLOOR_S[7:0] : gap_raw[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg     <= S_OFF;
      gap_cnt_reg <= 8'(MIN_GAP);
      type_q_reg  <= 2'd0;
    end else begin
      fsm_reg     <= fsm_next;
      gap_cnt_reg <= gap_cnt_next;
      type_q_reg  <= type_q_next;
    end
  end

  always_comb begin
    fsm_next     = fsm_reg;
    gap_cnt_next = gap_cnt_reg;
    type_q_next  = type_q_reg;
    if (state != RUN) begin
      // A handshake completing in this cycle still counts; nothing to undo.
      fsm_next     = S_OFF;
      gap_cnt_next = 8'(MIN_GAP);
    end else begin
      case (fsm_reg)
        S_OFF: begin
          fsm_next     = S_GAP;
          gap_cnt_next = 8'(MIN_GAP);
        end
        S_GAP: begin
          if (frame_tick) begin
            if (gap_cnt_reg <= 8'd1) begin
              gap_cnt_next = 8'd0;
              fsm_next     = S_SAMPLE;
            end else begin
              gap_cnt_next = gap_cnt_reg - 8'd1;
            end
          end
        end
        S_SAMPLE: begin
          type_q_next = rnd;
          if (rnd == 2'd0) begin
            // Empty slot: short re-sample gap, no offer.
            gap_cnt_next = 8'(GAP_STEP);
            fsm_next     = S_GAP;
          end else begin
            fsm_next = S_OFFER;
          end
        end
        S_OFFER: begin
          if (spawn_ready) begin
            gap_cnt_next = gap_reload;
            fsm_next     = S_GAP;
          end
        end
        default: fsm_next = S_OFF;
      endcase
    end
  end

  // Decoded straight from the state register so an asynchronous reset
  // withdraws the offer immediately.
  assign spawn_valid = (fsm_reg == S_OFFER);
  assign spawn_type  = spawn_valid ? type_q_reg : 2'd0;

endmodule

// File: tb/tb_obstacle_spawn_scheduler.sv
module tb_obstacle_spawn_scheduler;
  import dino_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  state_t     state;
  logic       frame_tick;
  logic [1:0] rnd;
  logic [9:0] score;
  logic       spawn_ready;
  logic       spawn_valid;
  logic [1:0] spawn_type;
  logic [1:0] level;
  logic [3:0] mcnt1;
  logic [3:0] mcnt2;

  obstacle_spawn_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .state       (state),
    .frame_tick  (frame_tick),
    .rnd         (rnd),
    .score       (score),
    .spawn_ready (spawn_ready),
    .spawn_valid (spawn_valid),
    .spawn_type  (spawn_type),
    .level       (level),
    .mcnt1       (mcnt1),
    .mcnt2       (mcnt2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int tick_count = 0;
  int xfer_count = 0;

  typedef struct {
    logic [1:0] typ;
    int         tick;
    string      name;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic push_exp(input logic [1:0] typ, input int tick, input string name);
    exp_t e;
    e.typ = typ; e.tick = tick; e.name = name;
    exp_q.push_back(e);
  endtask

  // Advance n rising edges, then settle 2 ns past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One frame tick followed by idle cycles, so no tick lands in the
  // sample/offer cycles while ready is high.
  task automatic tick();
    frame_tick = 1'b1;
    tick_count++;
    step(1);
    frame_tick = 1'b0;
    step(3);
  endtask

  // Monitor: pops an expectation on every new offer; checks type, which
  // tick it follows and that it appears two cycles after that tick.
  logic       valid_prev = 1'b0;
  logic [1:0] held_type = 2'd0;
  int         cyc_since_tick = 0;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (frame_tick) cyc_since_tick = 0;
    else            cyc_since_tick++;
    if (rst_n && spawn_valid && !valid_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_offer: got type %0d at tick %0d, expected no offer",
                 spawn_type, tick_count);
      end else begin
        mon_e = exp_q.pop_front();
        check({mon_e.name, "_type"}, int'(spawn_type), int'(mon_e.typ));
        check({mon_e.name, "_tick"}, tick_count, mon_e.tick);
        check({mon_e.name, "_lat"}, cyc_since_tick, 2);
      end
      held_type = spawn_type;
    end else if (rst_n && spawn_valid && valid_prev) begin
      if (spawn_type != held_type)
        check("offer_type_stable", int'(spawn_type), int'(held_type));
    end
    if (rst_n && spawn_valid && spawn_ready) xfer_count++;
    valid_prev = spawn_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int x0;
    rst_n = 1'b0; state = IDLE; frame_tick = 1'b0; rnd = 2'd0;
    score = 10'd0; spawn_ready = 1'b0;
    step(3);
    check("rst_valid", int'(spawn_valid), 0);
    check("rst_type",  int'(spawn_type), 0);
    check("rst_level", int'(level), 0);
    check("rst_mcnt1", int'(mcnt1), 7);
    check("rst_mcnt2", int'(mcnt2), 2);
    rst_n = 1'b1;
    step(2);

    // 1: steady run, type 2, ready high
    state = RUN; rnd = 2'd2; spawn_ready = 1'b1;
    step(2);
    push_exp(2'd2, tick_count + 24, "t1_first");
    push_exp(2'd2, tick_count + 64, "t1_second");
    repeat (64) tick();

    // 2: renderer stalls for 50 cycles while rnd wanders
    spawn_ready = 1'b0;
    push_exp(2'd2, tick_count + 40, "t2_stall");
    repeat (40) tick();
    x0 = xfer_count;
    repeat (50) begin
      rnd = 2'($urandom_range(0, 3));
      step(1);
    end
    check("t2_valid_held", int'(spawn_valid), 1);
    check("t2_type_held",  int'(spawn_type), 2);
    check("t2_no_xfer",    xfer_count, x0);
    rnd = 2'd0;
    spawn_ready = 1'b1;
    step(2);
    check("t2_single_xfer", xfer_count, x0 + 1);
    check("t2_valid_drop",  int'(spawn_valid), 0);

    // 3: empty sample, then re-sample 8 ticks later
    repeat (40) tick();
    check("t3_no_valid", int'(spawn_valid), 0);
    rnd = 2'd3;
    push_exp(2'd3, tick_count + 8, "t3_resample");
    repeat (8) tick();

    // 4: level 3 shortens the gap to 20
    score = 10'd350;
    step(1);
    check("t4_level", int'(level), 3);
    step(1);
    check("t4_mcnt1", int'(mcnt1), 4);
    check("t4_mcnt2", int'(mcnt2), 3);
    rnd = 2'd1;
    push_exp(2'd1, tick_count + 48, "t4_first");
    push_exp(2'd1, tick_count + 68, "t4_short_gap");
    repeat (68) tick();

    // 5: leave RUN mid-gap, level hold/clear, fresh start
    repeat (5) tick();
    state = OVER; score = 10'd0;
    step(2);
    check("t5_over_valid", int'(spawn_valid), 0);
    check("t5_over_level", int'(level), 3);
    check("t5_over_mcnt1", int'(mcnt1), 4);
    state = IDLE;
    step(1);
    check("t5_idle_level", int'(level), 0);
    step(1);
    check("t5_idle_mcnt1", int'(mcnt1), 7);
    check("t5_idle_mcnt2", int'(mcnt2), 2);
    state = RUN;
    step(2);
    push_exp(2'd1, tick_count + 24, "t5_restart");
    repeat (24) tick();

    // 6: asynchronous reset during an offer
    score = 10'd250; spawn_ready = 1'b0; rnd = 2'd2;
    step(2);
    check("t6_level", int'(level), 2);
    push_exp(2'd2, tick_count + 32, "t6_pre_reset");
    repeat (32) tick();
    check("t6_valid_before", int'(spawn_valid), 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", int'(spawn_valid), 0);
    check("t6_rst_type",  int'(spawn_type), 0);
    check("t6_rst_level", int'(level), 0);
    check("t6_rst_mcnt1", int'(mcnt1), 7);
    check("t6_rst_mcnt2", int'(mcnt2), 2);
    step(2);
    state = IDLE;
    rst_n = 1'b1;
    step(3);

    check("end_pending", exp_q.size(), 0);
    check("end_xfers", xfer_count, 7);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
